muldiv_scheduler: RTL and testbench
===================================

// Module: muldiv_scheduler
// PURPOSE
//  Shared RV32M execution resource for the dual-issue core. Lane 0 (older) and lane 1 (younger)
//  each offer a mul/div/rem op tagged with its 5-bit aluctrl code. The block arbitrates, runs
//  one op at a time: multiply over a fixed number of cycles, divide/rem with a 1-bit/cycle
//  iterative divider. It returns one tagged result per op over a valid/ready handshake.
// PARAMETERS
//  XLEN        32  operand/result width (only 32 is supported)
//  TAG_W       4   width of the issue tag carried from request to response
//  MUL_STAGES  1   cycles spent in MUL state (legal 1..3); mul latency = MUL_STAGES+1
// PORTS
//  clk          in   1      clock, rising edge
//  rst          in   1      reset, asynchronous, active-high
//  flush        in   1      synchronous pipeline flush; kills in-flight op
//  req0_valid   in   1      lane0 request valid
//  req0_ready   out  1      lane0 request accepted this cycle when valid&ready
//  req0_op      in   5      lane0 aluctrl code
//  req0_a       in   XLEN   lane0 rs1 value
//  req0_b       in   XLEN   lane0 rs2 value
//  req0_tag     in   TAG_W  lane0 tag
//  req1_*       -    -      lane1 request; same set and widths as req0_*
//  resp_valid   out  1      result valid; held until resp_ready
//  resp_ready   in   1      consumer accepts result
//  resp_lane    out  1      lane that issued the op (0/1)
//  resp_tag     out  TAG_W  tag of the completed op
//  resp_data    out  XLEN   result
//  resp_err     out  1      op code was not an M-extension code; resp_data=0
//  busy         out  1      state != IDLE
// BEHAVIOUR
//  - Reset: state IDLE; resp_valid, resp_lane, resp_tag, resp_data, resp_err, busy all 0.
//  - Op codes: MUL 01111, MULH 10000, MULHSU 10001, MULHU 10010, DIV 01101, DIVU 01110,
//    REM 10011, REMU 10100. Any other code is accepted, goes straight to DONE, resp_err=1.
//  - Arbitration (IDLE only): lane0 has fixed priority. reqN_ready is combinational:
//    req0_ready = IDLE & !flush; req1_ready = IDLE & !flush & !req0_valid.
//    At most one acceptance per cycle. Operands, op, tag and lane are latched on acceptance.
//  - FSM: IDLE -> MUL (mul ops) | DIV (div/rem) | DONE (illegal op, div-by-0, overflow).
//    MUL: the 64-bit product is formed from sign-/zero-extended operands per op and
//    registered. After MUL_STAGES cycles the FSM goes to DONE. MUL returns low 32 bits;
//    MULH/MULHSU/MULHU return high 32 bits.
//    DIV: operands are converted to magnitudes (signed ops). Exactly 32 iterations follow,
//    one cycle each, then DONE. Sign fixup is applied on the DONE transition:
//    quotient negated if signs differ; remainder takes the dividend's sign.
//    DONE: resp_valid=1, outputs stable; on resp_ready -> IDLE next cycle.
//  - Latency from acceptance to resp_valid: mul MUL_STAGES+1; div/rem 33; special cases 1.
//    Throughput: at most one acceptance per op. The earliest next acceptance is the cycle
//    after the resp handshake.
//  - Special cases (RISC-V semantics, no trap): divisor 0 -> DIV/DIVU q=32'hFFFFFFFF,
//    REM/REMU r=dividend. Signed 32'h80000000 / -1 -> q=32'h80000000, r=0.
//  - flush: from any state -> IDLE next cycle; resp_valid deasserts; the killed op never
//    responds. A flush in the same cycle as resp handshake is also legal: IDLE next cycle.
//  - rst mid-operation: immediate IDLE, all outputs to reset values; the op is lost.
//  - resp_ready low in DONE: hold indefinitely; no new request accepted (both ready=0).
// STRUCTURE
//  - Shared package riscv_pkg: localparams for all 5-bit aluctrl codes (ALU_MUL, ALU_DIV, ...)
//    and the FSM state encoding (IDLE, MUL, DIV, DONE).
//  - One sub-module md_div_iter holds the restoring-divider datapath:
//    start, 32-step counter, quotient/remainder registers and done pulse.
//  - Arbiter, FSM, multiplier and sign fixup stay in this module.
// TESTING
//  1 MUL lane0 a=7 b=-3 tag=5 -> resp_data=32'hFFFFFFEB, resp_tag=5, resp_lane=0,
//    valid MUL_STAGES+1 cycles after accept.
//  2 Both lanes valid in IDLE, lane0 MULHU a=b=32'hFFFFFFFF, lane1 DIVU -> lane0 first:
//    resp 32'hFFFFFFFE. Lane1 is accepted the cycle after the handshake.
//  3 DIV a=-20 b=6 -> q=-3 (32'hFFFFFFFD) after 33 cycles; REM same operands -> r=-2.
//  4 DIVU b=0 -> 32'hFFFFFFFF in 1 cycle; REM a=32'h80000000 b=-1 -> 0; DIV same -> 32'h80000000.
//  5 flush at iteration 10 of a DIV -> busy=0 next cycle, no resp; a following MUL completes
//    normally. Async rst mid-MUL -> all outputs 0 immediately.
//  6 resp_ready held low 5 cycles in DONE -> resp stable, req ready=0. Illegal op 00010
//    -> resp_err=1, resp_data=0.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RV32 definitions: aluctrl codes for the M extension and the mul/div scheduler state encoding.
package riscv_pkg;

  localparam int unsigned ALU_OP_W = 5;

  localparam logic [ALU_OP_W-1:0] ALU_DIV    = 5'b01101;
  localparam logic [ALU_OP_W-1:0] ALU_DIVU   = 5'b01110;
  localparam logic [ALU_OP_W-1:0] ALU_MUL    = 5'b01111;
  localparam logic [ALU_OP_W-1:0] ALU_MULH   = 5'b10000;
  localparam logic [ALU_OP_W-1:0] ALU_MULHSU = 5'b10001;
  localparam logic [ALU_OP_W-1:0] ALU_MULHU  = 5'b10010;
  localparam logic [ALU_OP_W-1:0] ALU_REM    = 5'b10011;
  localparam logic [ALU_OP_W-1:0] ALU_REMU   = 5'b10100;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } md_state_e;

  function automatic logic is_mul_op(input logic [ALU_OP_W-1:0] op);
    return (op == ALU_MUL) || (op == ALU_MULH) || (op == ALU_MULHSU) || (op == ALU_MULHU);
  endfunction

  function automatic logic is_div_op(input logic [ALU_OP_W-1:0] op);
    return (op == ALU_DIV) || (op == ALU_DIVU) || (op == ALU_REM) || (op == ALU_REMU);
  endfunction

endpackage

// File: rtl/md_div_iter.sv
// Restoring unsigned divider: one quotient bit per cycle, 32 steps after start.
// The step result is exposed combinationally so the caller can capture the final step directly.
module md_div_iter
  import riscv_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            start,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic            done_c,
  output logic [XLEN-1:0] quo_c,
  output logic [XLEN-1:0] rem_c
);

  localparam int unsigned CNT_W = $clog2(XLEN);

  logic [XLEN-1:0]  quo_q;
  logic [XLEN-1:0]  rem_q;
  logic [XLEN-1:0]  dvs_q;
  logic [CNT_W-1:0] cnt_q;
  logic             active_q;
  logic [XLEN:0]    rem_shift;
  logic             ge;

  // One restoring step: shift in the next dividend bit, subtract if it fits.
  always_comb begin
    rem_shift = {rem_q, quo_q[XLEN-1]};
    ge        = rem_shift >= {1'b0, dvs_q};
    quo_c     = {quo_q[XLEN-2:0], ge};
    rem_c     = ge ? XLEN'(rem_shift - {1'b0, dvs_q}) : rem_shift[XLEN-1:0];
    done_c    = active_q && (cnt_q == CNT_W'(XLEN - 1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      quo_q    <= '0;
      rem_q    <= '0;
      dvs_q    <= '0;
      cnt_q    <= '0;
      active_q <= 1'b0;
    end else if (flush) begin
      active_q <= 1'b0;
    end else if (start) begin
      quo_q    <= dividend;
      rem_q    <= '0;
      dvs_q    <= divisor;
      cnt_q    <= '0;
      active_q <= 1'b1;
    end else if (active_q) begin
      quo_q <= quo_c;
      rem_q <= rem_c;
      cnt_q <= cnt_q + 1'b1;
      if (done_c) active_q <= 1'b0;
    end
  end

endmodule

// File: rtl/muldiv_scheduler.sv
// Shared RV32M unit for the dual-issue core: arbitrates two lanes, runs one mul/div/rem
// at a time and returns one tagged result per accepted op over valid/ready.
module muldiv_scheduler
  import riscv_pkg::*;
#(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned TAG_W      = 4,
  parameter int unsigned MUL_STAGES = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic                req0_valid,
  output logic                req0_ready,
  input  logic [ALU_OP_W-1:0] req0_op,
  input  logic [XLEN-1:0]     req0_a,
  input  logic [XLEN-1:0]     req0_b,
  input  logic [TAG_W-1:0]    req0_tag,
  input  logic                req1_valid,
  output logic                req1_ready,
  input  logic [ALU_OP_W-1:0] req1_op,
  input  logic [XLEN-1:0]     req1_a,
  input  logic [XLEN-1:0]     req1_b,
  input  logic [TAG_W-1:0]    req1_tag,
  output logic                resp_valid,
  input  logic                resp_ready,
  output logic                resp_lane,
  output logic [TAG_W-1:0]    resp_tag,
  output logic [XLEN-1:0]     resp_data,
  output logic                resp_err,
  output logic                busy
);

  localparam int unsigned CNT_W = 2;
  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  md_state_e state_q, state_nxt;

  logic                accept0, accept1, accept;
  logic [ALU_OP_W-1:0] sel_op;
  logic [XLEN-1:0]     sel_a, sel_b;
  logic [TAG_W-1:0]    sel_tag;
  logic                sel_mul, sel_div, sel_signed, sel_rem;
  logic                div_zero, div_ovf, special;
  logic [XLEN-1:0]     special_data, mag_a, mag_b;

  logic [ALU_OP_W-1:0] op_q;
  logic [XLEN-1:0]     a_q, b_q;
  logic                neg_quo_q, neg_rem_q, is_rem_q;
  logic [CNT_W-1:0]    mul_cnt_q;

  logic [2*XLEN-1:0]   a_ext, b_ext, prod;
  logic [XLEN-1:0]     mul_res, div_res;
  logic                div_start, div_done_c;
  logic [XLEN-1:0]     div_quo_c, div_rem_c;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_nxt;
  end

  // Next-state logic; flush overrides everything
  always_comb begin
    state_nxt = state_q;
    case (state_q)
      IDLE: if (accept) state_nxt = special ? DONE : (sel_mul ? MUL : DIV);
      MUL:  if (mul_cnt_q == CNT_W'(MUL_STAGES - 1)) state_nxt = DONE;
      DIV:  if (div_done_c) state_nxt = DONE;
      DONE: if (resp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (flush) state_nxt = IDLE;
  end

  // Request-side handshake: lane0 wins, lane1 only when lane0 is silent
  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    if (state_q == IDLE && !flush) begin
      req0_ready = 1'b1;
      req1_ready = !req0_valid;
    end
  end

  assign accept0 = req0_valid && req0_ready;
  assign accept1 = req1_valid && req1_ready;
  assign accept  = accept0 || accept1;

  // Decode of the winning request, including the results that need no datapath
  always_comb begin
    sel_op     = accept1 ? req1_op  : req0_op;
    sel_a      = accept1 ? req1_a   : req0_a;
    sel_b      = accept1 ? req1_b   : req0_b;
    sel_tag    = accept1 ? req1_tag : req0_tag;
    sel_mul    = is_mul_op(sel_op);
    sel_div    = is_div_op(sel_op);
    sel_signed = (sel_op == ALU_DIV) || (sel_op == ALU_REM);
    sel_rem    = (sel_op == ALU_REM) || (sel_op == ALU_REMU);
    div_zero   = sel_div && (sel_b == '0);
    div_ovf    = sel_signed && (sel_a == INT_MIN) && (sel_b == '1);
    special    = !sel_mul && (!sel_div || div_zero || div_ovf);
    special_data = '0;
    if (div_zero)     special_data = sel_rem ? sel_a : '1;
    else if (div_ovf) special_data = sel_rem ? '0 : INT_MIN;
    mag_a = (sel_signed && sel_a[XLEN-1]) ? -sel_a : sel_a;
    mag_b = (sel_signed && sel_b[XLEN-1]) ? -sel_b : sel_b;
  end

  assign div_start = accept && sel_div && !special;

  // Operand latch and multiply stage counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      is_rem_q  <= 1'b0;
      mul_cnt_q <= '0;
    end else if (accept) begin
      op_q      <= sel_op;
      a_q       <= sel_a;
      b_q       <= sel_b;
      neg_quo_q <= sel_signed && (sel_a[XLEN-1] ^ sel_b[XLEN-1]);
      neg_rem_q <= sel_signed && sel_a[XLEN-1];
      is_rem_q  <= sel_rem;
      mul_cnt_q <= '0;
    end else if (state_q == MUL) begin
      mul_cnt_q <= mul_cnt_q + 1'b1;
    end
  end

  // Low 2*XLEN bits of the extended product are exact for every signedness mix
  always_comb begin
    a_ext   = (op_q == ALU_MULH || op_q == ALU_MULHSU) ? {{XLEN{a_q[XLEN-1]}}, a_q}
                                                       : {{XLEN{1'b0}}, a_q};
    b_ext   = (op_q == ALU_MULH) ? {{XLEN{b_q[XLEN-1]}}, b_q} : {{XLEN{1'b0}}, b_q};
    prod    = a_ext * b_ext;
    mul_res = (op_q == ALU_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    div_res = is_rem_q ? (neg_rem_q ? -div_rem_c : div_rem_c)
                       : (neg_quo_q ? -div_quo_c : div_quo_c);
  end

  md_div_iter #(.XLEN(XLEN)) u_div (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .start    (div_start),
    .dividend (mag_a),
    .divisor  (mag_b),
    .done_c   (div_done_c),
    .quo_c    (div_quo_c),
    .rem_c    (div_rem_c)
  );

  // Registered response and status outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resp_valid <= 1'b0;
      resp_lane  <= 1'b0;
      resp_tag   <= '0;
      resp_data  <= '0;
      resp_err   <= 1'b0;
      busy       <= 1'b0;
    end else begin
      resp_valid <= (state_nxt == DONE);
      busy       <= (state_nxt != IDLE);
      if (accept) begin
        resp_lane <= accept1;
        resp_tag  <= sel_tag;
        resp_data <= special_data;
        resp_err  <= !sel_mul && !sel_div;
      end else if (state_q == MUL && state_nxt == DONE) begin
        resp_data <= mul_res;
      end else if (state_q == DIV && state_nxt == DONE) begin
        resp_data <= div_res;
      end
    end
  end

endmodule

// File: tb/tb_muldiv_scheduler.sv
// Directed bench for muldiv_scheduler: vector table plus arbitration, flush, reset and backpressure sequences.
module tb_muldiv_scheduler;
  import riscv_pkg::*;

  logic        clk = 1'b0;
  logic        rst, flush;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [4:0]  req0_op, req1_op;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic [3:0]  req0_tag, req1_tag;
  logic        resp_valid, resp_ready, resp_lane, resp_err, busy;
  logic [3:0]  resp_tag;
  logic [31:0] resp_data;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic        lane;
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  tag;
    logic [31:0] exp_data;
    logic        exp_err;
    int          exp_lat;
  } vec_t;

  vec_t vecs[15];

  always #5 clk = ~clk;

  muldiv_scheduler #(.XLEN(32), .TAG_W(4), .MUL_STAGES(1)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b), .req0_tag(req0_tag),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b), .req1_tag(req1_tag),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_lane(resp_lane),
    .resp_tag(resp_tag), .resp_data(resp_data), .resp_err(resp_err), .busy(busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %h required %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic lane, input logic [4:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [3:0] tag);
    if (!lane) begin
      req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b; req0_tag = tag;
    end else begin
      req1_valid = 1'b1; req1_op = op; req1_a = a; req1_b = b; req1_tag = tag;
    end
  endtask

  // Present a request on one lane at a negedge; it is taken at the following posedge.
  task automatic issue(input logic lane, input logic [4:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [3:0] tag);
    @(negedge clk);
    drive(lane, op, a, b, tag);
    #1;
    check("req_ready", 32'(lane ? req1_ready : req0_ready), 32'd1);
    @(posedge clk);
    #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  // Cycles from acceptance until resp_valid is seen; 0 means the bound expired.
  task automatic wait_resp(output int lat);
    lat = 0;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      if (resp_valid) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic handshake();
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    resp_ready = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    int lat;
    issue(v.lane, v.op, v.a, v.b, v.tag);
    wait_resp(lat);
    check("latency",   32'(lat),       32'(v.exp_lat));
    check("resp_data", resp_data,      v.exp_data);
    check("resp_err",  32'(resp_err),  32'(v.exp_err));
    check("resp_tag",  32'(resp_tag),  32'(v.tag));
    check("resp_lane", 32'(resp_lane), 32'(v.lane));
    handshake();
    @(negedge clk);
    check("valid_after_hs", 32'(resp_valid), 32'd0);
    check("busy_after_hs",  32'(busy),       32'd0);
  endtask

  initial begin
    int  lat;
    logic seen;

    vecs[0]  = '{1'b0, ALU_MUL,    32'd7,        32'hFFFFFFFD, 4'd5,  32'hFFFFFFEB, 1'b0, 2};
    vecs[1]  = '{1'b0, ALU_MULH,   32'h80000000, 32'h80000000, 4'd1,  32'h40000000, 1'b0, 2};
    vecs[2]  = '{1'b1, ALU_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 4'd2,  32'hFFFFFFFF, 1'b0, 2};
    vecs[3]  = '{1'b1, ALU_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 4'd3,  32'hFFFFFFFE, 1'b0, 2};
    vecs[4]  = '{1'b0, ALU_DIV,    32'hFFFFFFEC, 32'd6,        4'd4,  32'hFFFFFFFD, 1'b0, 33};
    vecs[5]  = '{1'b0, ALU_REM,    32'hFFFFFFEC, 32'd6,        4'd6,  32'hFFFFFFFE, 1'b0, 33};
    vecs[6]  = '{1'b1, ALU_DIVU,   32'd100,      32'd7,        4'd7,  32'd14,       1'b0, 33};
    vecs[7]  = '{1'b0, ALU_REMU,   32'd100,      32'd7,        4'd8,  32'd2,        1'b0, 33};
    vecs[8]  = '{1'b0, ALU_DIV,    32'd20,       32'hFFFFFFFA, 4'd9,  32'hFFFFFFFD, 1'b0, 33};
    vecs[9]  = '{1'b1, ALU_REM,    32'd20,       32'hFFFFFFFA, 4'd10, 32'd2,        1'b0, 33};
    vecs[10] = '{1'b0, ALU_DIVU,   32'd55,       32'd0,        4'd11, 32'hFFFFFFFF, 1'b0, 1};
    vecs[11] = '{1'b0, ALU_REM,    32'd1234,     32'd0,        4'd12, 32'd1234,     1'b0, 1};
    vecs[12] = '{1'b0, ALU_REM,    32'h80000000, 32'hFFFFFFFF, 4'd13, 32'd0,        1'b0, 1};
    vecs[13] = '{1'b1, ALU_DIV,    32'h80000000, 32'hFFFFFFFF, 4'd14, 32'h80000000, 1'b0, 1};
    vecs[14] = '{1'b0, 5'b00010,   32'd9,        32'd3,        4'd15, 32'd0,        1'b1, 1};

    rst = 1'b1; flush = 1'b0; resp_ready = 1'b0;
    req0_valid = 1'b0; req0_op = '0; req0_a = '0; req0_b = '0; req0_tag = '0;
    req1_valid = 1'b0; req1_op = '0; req1_a = '0; req1_b = '0; req1_tag = '0;
    repeat (2) @(negedge clk);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_busy",       32'(busy),       32'd0);
    check("rst_resp_data",  resp_data,       32'd0);
    check("rst_resp_tag",   32'(resp_tag),   32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_req0_ready", 32'(req0_ready), 32'd1);

    for (int i = 0; i < 15; i++) run_vec(vecs[i]);

    // Both lanes at once: lane0 first, lane1 taken right after the handshake
    @(negedge clk);
    drive(1'b0, ALU_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 4'd1);
    drive(1'b1, ALU_DIVU, 32'd100, 32'd7, 4'd2);
    #1;
    check("arb_req0_ready", 32'(req0_ready), 32'd1);
    check("arb_req1_ready", 32'(req1_ready), 32'd0);
    @(posedge clk);
    #1;
    req0_valid = 1'b0;
    wait_resp(lat);
    check("arb_lat0",  32'(lat),       32'd2);
    check("arb_data0", resp_data,      32'hFFFFFFFE);
    check("arb_lane0", 32'(resp_lane), 32'd0);
    check("arb_req1_blocked", 32'(req1_ready), 32'd0);
    handshake();
    @(negedge clk);
    check("arb_req1_ready_after", 32'(req1_ready), 32'd1);
    @(posedge clk);
    #1;
    req1_valid = 1'b0;
    wait_resp(lat);
    check("arb_lat1",  32'(lat),       32'd33);
    check("arb_data1", resp_data,      32'd14);
    check("arb_lane1", 32'(resp_lane), 32'd1);
    check("arb_tag1",  32'(resp_tag),  32'd2);
    handshake();

    // Flush during divide iteration 10 kills the op
    issue(1'b0, ALU_DIV, 32'd1000, 32'd3, 4'd6);
    repeat (10) @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    check("flush_busy",  32'(busy),       32'd0);
    check("flush_valid", 32'(resp_valid), 32'd0);
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (resp_valid) seen = 1'b1;
    end
    check("flush_no_resp", 32'(seen), 32'd0);
    run_vec('{1'b0, ALU_MUL, 32'd12, 32'd12, 4'd9, 32'd144, 1'b0, 2});

    // Asynchronous reset while in MUL
    issue(1'b0, ALU_MUL, 32'd3, 32'd5, 4'd10);
    check("mul_busy",     32'(busy),     32'd1);
    check("mul_tag_held", 32'(resp_tag), 32'd10);
    #1;
    rst = 1'b1;
    #1;
    check("arst_busy",  32'(busy),       32'd0);
    check("arst_valid", 32'(resp_valid), 32'd0);
    check("arst_tag",   32'(resp_tag),   32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("arst_no_resp",     32'(resp_valid), 32'd0);
    check("arst_idle_ready",  32'(req0_ready), 32'd1);

    // Backpressure: response held, no requests accepted
    issue(1'b0, ALU_MUL, 32'd2, 32'd3, 4'd3);
    wait_resp(lat);
    check("hold_lat", 32'(lat), 32'd2);
    drive(1'b0, 5'b00010, 32'd1, 32'd1, 4'd1);
    drive(1'b1, ALU_MUL, 32'd1, 32'd1, 4'd2);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold_valid",  32'(resp_valid), 32'd1);
      check("hold_data",   resp_data,       32'd6);
      check("hold_tag",    32'(resp_tag),   32'd3);
      check("hold_ready0", 32'(req0_ready), 32'd0);
      check("hold_ready1", 32'(req1_ready), 32'd0);
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    handshake();
    @(negedge clk);
    check("hold_released", 32'(resp_valid), 32'd0);

    // Flush coinciding with the response handshake
    issue(1'b1, ALU_MULH, 32'd4, 32'd4, 4'd4);
    wait_resp(lat);
    check("fhs_data", resp_data, 32'd0);
    resp_ready = 1'b1;
    flush = 1'b1;
    @(posedge clk);
    #1;
    resp_ready = 1'b0;
    flush = 1'b0;
    @(negedge clk);
    check("fhs_busy",  32'(busy),       32'd0);
    check("fhs_valid", 32'(resp_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
